seq_detect_prog: RTL

Programmable serial bit-pattern detector, the parametrised successor of the fixed 4-bit sequence detectors in the stimulus/monitor path. It samples one qualified bit per cycle and compares the most recent `pat_len` bits against a runtime-loadable pattern of up to `PAT_W` bits. It pulses `seq_seen` on each match, supports overlapping and non-overlapping detection, and can optionally keep a saturating match count.

---
 rtl/seq_detect_prog.sv | 79 +++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlap control.
// Define SEQ_DETECT_PROG_COUNT_EN to build the saturating match counter.
module seq_detect_prog #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_1011,
  parameter int               RST_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             inp_valid,
  input  logic             inp_bit,
  input  logic             clr_count,
  output logic             seq_seen,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  logic [PAT_W-1:0] hist, pat, hist_nx, mask;
  logic [LEN_W-1:0] len, fill, fill_nx, load_len;
  logic             match;

  always_comb begin
    hist_nx = {hist[PAT_W-2:0], inp_bit};
    fill_nx = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    // Only the low len bits of the pattern take part in the compare.
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(len));
    match = inp_valid && !pat_load && (fill_nx >= len) &&
            ((hist_nx & mask) == (pat & mask));
    load_len = (pat_len == '0 || pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat      <= RST_PAT;
      len      <= LEN_W'(RST_LEN);
      hist     <= '0;
      fill     <= '0;
      seq_seen <= 1'b0;
    end else if (pat_load) begin
      pat      <= pat_value;
      len      <= load_len;
      hist     <= '0;
      fill     <= '0;
      seq_seen <= 1'b0;
    end else if (inp_valid) begin
      hist     <= hist_nx;
      fill     <= (match && !overlap_en) ? '0 : fill_nx;
      seq_seen <= match;
    end else begin
      seq_seen <= 1'b0;
    end
  end

`ifdef SEQ_DETECT_PROG_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (clr_count)         cnt <= '0;
    else if (match && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign match_count = cnt;
  assign count_sat   = &cnt;
`else
  logic unused_clr;
  assign unused_clr  = clr_count;
  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule
